// File: rtl/btb_resolve_if.sv
// BTB write-port handshake: the resolve unit (master) offers queued updates,
// the BTB (slave) accepts the head with upd_ready.
interface btb_resolve_if #(
  parameter int IDX_W = 7
);
  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic [31:0]      upd_target;
  logic [1:0]       upd_flag;

  modport master (output upd_valid, upd_idx, upd_target, upd_flag, input upd_ready);
  modport slave  (input upd_valid, upd_idx, upd_target, upd_flag, output upd_ready);
endinterface

// File: rtl/btb_resolve.sv
// ID-stage branch resolution: compares the BTB prediction carried from IF against
// the resolved next PC, pulses a redirect on mismatch and queues BTB updates.
module btb_resolve #(
  parameter int IDX_W  = 7,
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  input  logic [31:0]        if_pc,
  input  logic               if_hit,
  input  logic [1:0]         if_flag,
  input  logic [31:0]        if_target,
  input  logic               stall_D,
  input  logic               flush_D,
  input  logic [1:0]         id_pcsrc,
  input  logic [31:0]        id_pc_offset,
  input  logic [31:0]        id_pc_offset_j,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  btb_resolve_if.master      upd,
  output logic [15:0]        mispredict_cnt,
  output logic [7:0]         drop_cnt
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      target;
    logic [1:0]       flag;
  } upd_t;

  logic        vld_q, hit_q;
  logic [31:0] pc_q, target_q;
  logic [1:0]  flag_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;
  logic [15:0] mispredict_cnt_q;
  logic [7:0]  drop_cnt_q;
  upd_t        mem_q [QDEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;

  logic        resolve_s, act_taken_s, mispredict_s, push_s, pop_s, full_s, accept_s, drop_s;
  logic [31:0] pc_plus4_s, pred_pc_s, act_pc_s;
  upd_t        push_d;

  always_comb begin
    resolve_s   = vld_q & ~stall_D & ~flush_D & ~redirect_q;
    pc_plus4_s  = pc_q + 32'd4;
    pred_pc_s   = (hit_q & flag_q[1]) ? target_q : pc_plus4_s;
    act_taken_s = (id_pcsrc == 2'b01) | (id_pcsrc == 2'b10);
    case (id_pcsrc)
      2'b01:   act_pc_s = id_pc_offset;
      2'b10:   act_pc_s = id_pc_offset_j;
      default: act_pc_s = pc_plus4_s;
    endcase
    mispredict_s = resolve_s & (pred_pc_s != act_pc_s);
    push_d.idx   = pc_q[IDX_W+1:2];
    if (hit_q) begin
      push_s        = resolve_s;
      push_d.target = act_taken_s ? act_pc_s : target_q;
      if (act_taken_s) begin
        push_d.flag = (flag_q == 2'b11) ? 2'b11 : flag_q + 2'b01;
      end else begin
        push_d.flag = (flag_q == 2'b00) ? 2'b00 : flag_q - 2'b01;
      end
    end else begin
      // A miss only allocates an entry when the branch was actually taken.
      push_s        = resolve_s & act_taken_s;
      push_d.target = act_pc_s;
      push_d.flag   = 2'b11;
    end
  end

  always_comb begin
    pop_s    = (count_q != '0) & upd.upd_ready;
    full_s   = (count_q == DEPTH_C);
    accept_s = push_s & (~full_s | pop_s);
    drop_s   = push_s & full_s & ~pop_s;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q            <= 1'b0;
      pc_q             <= 32'd0;
      hit_q            <= 1'b0;
      flag_q           <= 2'b00;
      target_q         <= 32'd0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= 32'd0;
      mispredict_cnt_q <= 16'd0;
      drop_cnt_q       <= 8'd0;
      wr_q             <= '0;
      rd_q             <= '0;
      count_q          <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      // Redirect kills the wrong-path record sitting in ID during the pulse.
      if (flush_D || redirect_q) begin
        vld_q <= 1'b0;
      end else if (!stall_D) begin
        vld_q    <= if_valid;
        pc_q     <= if_pc;
        hit_q    <= if_hit;
        flag_q   <= if_flag;
        target_q <= if_target;
      end
      redirect_q <= mispredict_s;
      if (mispredict_s) begin
        redirect_pc_q <= act_pc_s;
        if (mispredict_cnt_q != 16'hFFFF) mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
      end
      if (drop_s && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (accept_s) begin
        mem_q[wr_q] <= push_d;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_s) rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign drop_cnt       = drop_cnt_q;
  assign upd.upd_valid  = (count_q != '0);
  assign upd.upd_idx    = mem_q[rd_q].idx;
  assign upd.upd_target = mem_q[rd_q].target;
  assign upd.upd_flag   = mem_q[rd_q].flag;
endmodule

// File: tb/tb_btb_resolve.sv
// Directed bench for btb_resolve: a table of single-branch resolutions plus
// sequences for backpressure, stall, flush and mid-run reset.
module tb_btb_resolve;
  logic        clk = 1'b0;
  logic        rst_n, if_valid, if_hit, stall_D, flush_D, redirect;
  logic [31:0] if_pc, if_target, id_pc_offset, id_pc_offset_j, redirect_pc;
  logic [1:0]  if_flag, id_pcsrc;
  logic [15:0] mispredict_cnt;
  logic [7:0]  drop_cnt;
  int          errors = 0;
  int          checks = 0;
  int          exp_mp = 0;
  int          nred;

  btb_resolve_if #(.IDX_W(7)) upd_if ();

  btb_resolve #(.IDX_W(7), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_hit(if_hit),
    .if_flag(if_flag), .if_target(if_target), .stall_D(stall_D), .flush_D(flush_D),
    .id_pcsrc(id_pcsrc), .id_pc_offset(id_pc_offset), .id_pc_offset_j(id_pc_offset_j),
    .redirect(redirect), .redirect_pc(redirect_pc), .upd(upd_if),
    .mispredict_cnt(mispredict_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic [1:0]  flag;
    logic [31:0] target;
    logic [1:0]  pcsrc;
    logic [31:0] off;
    logic [31:0] offj;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_push;
    logic [6:0]  e_idx;
    logic [31:0] e_target;
    logic [1:0]  e_flag;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_if(input logic [31:0] pc, input logic hit, input logic [1:0] flag,
                         input logic [31:0] tgt);
    if_valid = 1'b1; if_pc = pc; if_hit = hit; if_flag = flag; if_target = tgt;
  endtask

  task automatic set_id(input logic [1:0] pcsrc, input logic [31:0] off, input logic [31:0] offj);
    if_valid = 1'b0; id_pcsrc = pcsrc; id_pc_offset = off; id_pc_offset_j = offj;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_pc = 32'd0; if_hit = 1'b0; if_flag = 2'b00;
    if_target = 32'd0; stall_D = 1'b0; flush_D = 1'b0; id_pcsrc = 2'b00;
    id_pc_offset = 32'd0; id_pc_offset_j = 32'd0; upd_if.upd_ready = 1'b1;

    //           pc         hit   flag   target     pcsrc  off        offj       redir rpc        push  idx     target     flag
    vecs[0] = '{32'h100, 1'b0, 2'b00, 32'h0,   2'b01, 32'h140, 32'h0,    1'b1, 32'h140,  1'b1, 7'h40, 32'h140,  2'b11};
    vecs[1] = '{32'h1F0, 1'b1, 2'b10, 32'h200, 2'b10, 32'h0,   32'h200,  1'b0, 32'h0,    1'b1, 7'h7C, 32'h200,  2'b11};
    vecs[2] = '{32'h300, 1'b1, 2'b11, 32'h380, 2'b00, 32'h0,   32'h0,    1'b1, 32'h304,  1'b1, 7'h40, 32'h380,  2'b10};
    vecs[3] = '{32'h400, 1'b1, 2'b00, 32'h500, 2'b00, 32'h0,   32'h0,    1'b0, 32'h0,    1'b1, 7'h00, 32'h500,  2'b00};
    vecs[4] = '{32'h500, 1'b0, 2'b00, 32'h0,   2'b00, 32'h0,   32'h0,    1'b0, 32'h0,    1'b0, 7'h00, 32'h0,    2'b00};
    vecs[5] = '{32'h5F0, 1'b1, 2'b11, 32'h600, 2'b01, 32'h640, 32'h0,    1'b1, 32'h640,  1'b1, 7'h7C, 32'h640,  2'b11};
    vecs[6] = '{32'h700, 1'b1, 2'b01, 32'h800, 2'b11, 32'h0,   32'h0,    1'b0, 32'h0,    1'b1, 7'h40, 32'h800,  2'b00};
    vecs[7] = '{32'h0FC, 1'b0, 2'b00, 32'h0,   2'b10, 32'h0,   32'h1234, 1'b1, 32'h1234, 1'b1, 7'h3F, 32'h1234, 2'b11};
    vecs[8] = '{32'h020, 1'b1, 2'b01, 32'h99,  2'b01, 32'h40,  32'h0,    1'b1, 32'h40,   1'b1, 7'h08, 32'h40,   2'b10};

    step(); step();
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_upd_valid", {31'd0, upd_if.upd_valid}, 32'd0);
    chk("rst_upd_idx", {25'd0, upd_if.upd_idx}, 32'd0);
    chk("rst_upd_target", upd_if.upd_target, 32'd0);
    chk("rst_upd_flag", {30'd0, upd_if.upd_flag}, 32'd0);
    chk("rst_mp_cnt", {16'd0, mispredict_cnt}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      load_if(vecs[v].pc, vecs[v].hit, vecs[v].flag, vecs[v].target);
      step();
      set_id(vecs[v].pcsrc, vecs[v].off, vecs[v].offj);
      step();
      if (vecs[v].e_redir) exp_mp++;
      chk($sformatf("v%0d_redirect", v), {31'd0, redirect}, {31'd0, vecs[v].e_redir});
      if (vecs[v].e_redir) chk($sformatf("v%0d_redirect_pc", v), redirect_pc, vecs[v].e_rpc);
      chk($sformatf("v%0d_upd_valid", v), {31'd0, upd_if.upd_valid}, {31'd0, vecs[v].e_push});
      if (vecs[v].e_push) begin
        chk($sformatf("v%0d_upd_idx", v), {25'd0, upd_if.upd_idx}, {25'd0, vecs[v].e_idx});
        chk($sformatf("v%0d_upd_target", v), upd_if.upd_target, vecs[v].e_target);
        chk($sformatf("v%0d_upd_flag", v), {30'd0, upd_if.upd_flag}, {30'd0, vecs[v].e_flag});
      end
      chk($sformatf("v%0d_mp_cnt", v), {16'd0, mispredict_cnt}, exp_mp);
      id_pcsrc = 2'b00;
      step();
      chk($sformatf("v%0d_redirect_end", v), {31'd0, redirect}, 32'd0);
      chk($sformatf("v%0d_drained", v), {31'd0, upd_if.upd_valid}, 32'd0);
    end

    // Backpressure: five correctly predicted jumps, only four fit.
    upd_if.upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_if(32'h1000 + 32'(16 * i), 1'b1, 2'b10, 32'h2000 + 32'(i));
      step();
      set_id(2'b10, 32'h0, 32'h2000 + 32'(i));
      step();
      chk($sformatf("bp%0d_no_redirect", i), {31'd0, redirect}, 32'd0);
      chk($sformatf("bp%0d_head_idx", i), {25'd0, upd_if.upd_idx}, 32'd0);
      chk($sformatf("bp%0d_head_target", i), upd_if.upd_target, 32'h2000);
      id_pcsrc = 2'b00;
    end
    chk("bp_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    upd_if.upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop%0d_valid", i), {31'd0, upd_if.upd_valid}, 32'd1);
      chk($sformatf("pop%0d_idx", i), {25'd0, upd_if.upd_idx}, 32'(4 * i));
      chk($sformatf("pop%0d_target", i), upd_if.upd_target, 32'h2000 + 32'(i));
      chk($sformatf("pop%0d_flag", i), {30'd0, upd_if.upd_flag}, 32'd3);
      step();
    end
    chk("pop_empty", {31'd0, upd_if.upd_valid}, 32'd0);

    // Stall a mispredicting record for three cycles: one redirect, after release.
    load_if(32'h900, 1'b0, 2'b00, 32'h0);
    step();
    set_id(2'b01, 32'h940, 32'h0);
    stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_redirect", i), {31'd0, redirect}, 32'd0);
      chk($sformatf("stall%0d_upd_valid", i), {31'd0, upd_if.upd_valid}, 32'd0);
    end
    stall_D = 1'b0;
    nred = 0;
    step();
    chk("stall_rel_redirect_pc", redirect_pc, 32'h940);
    for (int i = 0; i < 3; i++) begin
      if (redirect) nred++;
      step();
    end
    exp_mp++;
    chk("stall_redirect_count", 32'(nred), 32'd1);
    chk("stall_mp_cnt", {16'd0, mispredict_cnt}, exp_mp);

    // Flush in the resolve cycle suppresses everything.
    id_pcsrc = 2'b00;
    load_if(32'hA00, 1'b0, 2'b00, 32'h0);
    step();
    set_id(2'b01, 32'hA40, 32'h0);
    flush_D = 1'b1;
    step();
    flush_D = 1'b0;
    chk("flush_redirect", {31'd0, redirect}, 32'd0);
    chk("flush_upd_valid", {31'd0, upd_if.upd_valid}, 32'd0);
    step();
    chk("flush_redirect_late", {31'd0, redirect}, 32'd0);
    chk("flush_mp_cnt", {16'd0, mispredict_cnt}, exp_mp);

    // Reset with a queued update and a pending redirect.
    upd_if.upd_ready = 1'b0;
    load_if(32'hB00, 1'b0, 2'b00, 32'h0);
    step();
    set_id(2'b01, 32'hB80, 32'h0);
    step();
    exp_mp++;
    chk("pre_rst_redirect", {31'd0, redirect}, 32'd1);
    chk("pre_rst_upd_valid", {31'd0, upd_if.upd_valid}, 32'd1);
    chk("pre_rst_mp_cnt", {16'd0, mispredict_cnt}, exp_mp);
    rst_n = 1'b0;
    id_pcsrc = 2'b00;
    step();
    chk("mid_rst_upd_valid", {31'd0, upd_if.upd_valid}, 32'd0);
    chk("mid_rst_redirect", {31'd0, redirect}, 32'd0);
    chk("mid_rst_upd_idx", {25'd0, upd_if.upd_idx}, 32'd0);
    chk("mid_rst_mp_cnt", {16'd0, mispredict_cnt}, 32'd0);
    chk("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
